// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - producer/FIFO write-side bundle shared by fifo_wr_arbiter
interface fifo_wr_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
);
  logic [NREQ-1:0]        req;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        gnt;
  logic [CNT_W-1:0]       fifo_words;
  logic                   wr_en;
  logic [DATA_W-1:0]      fifo_data;
  logic                   throttled;

  // master: producers plus FIFO status; slave: the arbiter itself
  modport master (
    output req, req_data, fifo_words,
    input  gnt, wr_en, fifo_data, throttled
  );

  modport slave (
    input  req, req_data, fifo_words,
    output gnt, wr_en, fifo_data, throttled
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for one FIFO write port with watermark throttle
module fifo_wr_arbiter #(
  parameter int NREQ    = 4,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 4,
  parameter int HIGH_WM = 5,
  parameter int LOW_WM  = 2,
  parameter int BURST   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_wr_arbiter_if.slave   bus
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BC_W  = (BURST > 1) ? $clog2(BURST) : 1;

  localparam logic [CNT_W-1:0] HIGH_WM_C = CNT_W'(HIGH_WM);
  localparam logic [CNT_W-1:0] LOW_WM_C  = CNT_W'(LOW_WM);
  localparam logic [BC_W-1:0]  LAST_BEAT = BC_W'(BURST - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT     = 2'd1,
    THROTTLED = 2'd2
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  rr_ptr;
  logic [BC_W-1:0]   beat_cnt;

  logic              hi_wm;
  logic              lo_wm;
  logic [IDX_W-1:0]  owner_nxt;
  logic              win_found;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W-1:0]  cand;
  logic [NREQ-1:0]   gnt_v;
  logic [DATA_W-1:0] data_arr [NREQ];

  assign hi_wm     = (bus.fifo_words >= HIGH_WM_C);
  assign lo_wm     = (bus.fifo_words <= LOW_WM_C);
  assign owner_nxt = (owner == LAST_IDX) ? '0 : owner + 1'b1;

  // First asserted request scanning upward from rr_ptr, wrapping at NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NREQ);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      data_arr[i] = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  // Gating on hi_wm here, not in the FSM, is what keeps occupancy from overshooting.
  always_comb begin
    gnt_v = '0;
    if (state == GRANT && bus.req[owner] && !hi_wm) begin
      gnt_v[owner] = 1'b1;
    end
  end

  assign bus.gnt       = gnt_v;
  assign bus.wr_en     = |gnt_v;
  assign bus.fifo_data = (|gnt_v) ? data_arr[owner] : '0;
  assign bus.throttled = (state == THROTTLED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hi_wm) begin
            state <= THROTTLED;
          end else if (win_found) begin
            owner    <= win_idx;
            beat_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          // Watermark outranks both req drop and burst end.
          if (hi_wm) begin
            state  <= THROTTLED;
            rr_ptr <= owner_nxt;
          end else if (!bus.req[owner]) begin
            state  <= IDLE;
            rr_ptr <= owner_nxt;
          end else if (beat_cnt == LAST_BEAT) begin
            state  <= IDLE;
            rr_ptr <= owner_nxt;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        THROTTLED: begin
          if (lo_wm) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  fifo_wr_arbiter_if #(.NREQ(4), .DATA_W(8), .CNT_W(4)) bus ();

  fifo_wr_arbiter #(
    .NREQ(4), .DATA_W(8), .CNT_W(4), .HIGH_WM(5), .LOW_WM(2), .BURST(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] eg, input logic [7:0] ed, input logic et);
    check({tag, "_gnt"},   32'(bus.gnt),       32'(eg));
    check({tag, "_wr_en"}, 32'(bus.wr_en),     32'(|eg));
    check({tag, "_data"},  32'(bus.fifo_data), 32'(ed));
    check({tag, "_thr"},   32'(bus.throttled), 32'(et));
  endtask

  // Inputs change 2 time units after each rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [3:0] oh;
    int         idx;
    n_cmp          = 0;
    n_bad          = 0;
    rst_n          = 1'b0;
    bus.req        = 4'b0000;
    bus.req_data   = {8'h33, 8'h22, 8'h55, 8'h11};
    bus.fifo_words = 4'd0;
    #2;
    expect_out("rst_init", 4'b0000, 8'h00, 1'b0);

    // Reset aborts a live grant immediately.
    rst_n   = 1'b1;
    bus.req = 4'b0010;
    #1;
    expect_out("rst_idle", 4'b0000, 8'h00, 1'b0);
    tick();
    expect_out("rst_gnt1", 4'b0010, 8'h55, 1'b0);
    rst_n = 1'b0;
    #1;
    expect_out("rst_async", 4'b0000, 8'h00, 1'b0);
    bus.req = 4'b1000;
    rst_n   = 1'b1;
    #1;
    expect_out("rst_bubble", 4'b0000, 8'h00, 1'b0);
    tick();
    expect_out("rst_gnt3", 4'b1000, 8'h33, 1'b0);
    bus.req = 4'b0000;
    tick();

    // Single producer: bubble then three beats, repeating.
    bus.req = 4'b0001;
    for (int rep = 0; rep < 2; rep++) begin
      expect_out("single_bubble", 4'b0000, 8'h00, 1'b0);
      for (int b = 0; b < 3; b++) begin
        tick();
        expect_out("single_beat", 4'b0001, 8'h11, 1'b0);
      end
      tick();
    end
    bus.req = 4'b0000;
    tick();

    // Full contention from rr_ptr=0.
    pulse_reset();
    bus.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus.req      = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      idx = g % 4;
      oh  = 4'b0001 << idx;
      expect_out("rr_bubble", 4'b0000, 8'h00, 1'b0);
      for (int b = 0; b < 3; b++) begin
        tick();
        expect_out("rr_beat", oh, 8'(8'hA0 + idx), 1'b0);
      end
      tick();
    end

    // Hysteresis: owner 1 is interrupted, resume goes to owner 2.
    tick();
    expect_out("hys_gnt1", 4'b0010, 8'hA1, 1'b0);
    bus.fifo_words = 4'd5;
    #1;
    expect_out("hys_block", 4'b0000, 8'h00, 1'b0);
    tick();
    expect_out("hys_thr5", 4'b0000, 8'h00, 1'b1);
    bus.fifo_words = 4'd3;
    tick();
    expect_out("hys_thr3", 4'b0000, 8'h00, 1'b1);
    bus.fifo_words = 4'd2;
    tick();
    expect_out("hys_idle", 4'b0000, 8'h00, 1'b0);
    tick();
    expect_out("hys_next", 4'b0100, 8'hA2, 1'b0);
    bus.fifo_words = 4'd0;

    // Early release: owner 0 drops after one beat.
    pulse_reset();
    bus.req_data = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
    bus.req      = 4'b0101;
    expect_out("early_bubble", 4'b0000, 8'h00, 1'b0);
    tick();
    expect_out("early_beat0", 4'b0001, 8'hB0, 1'b0);
    tick();
    bus.req = 4'b0100;
    #1;
    expect_out("early_drop", 4'b0000, 8'h00, 1'b0);
    tick();
    expect_out("early_idle", 4'b0000, 8'h00, 1'b0);
    for (int b = 0; b < 3; b++) begin
      tick();
      expect_out("early_gnt2", 4'b0100, 8'hB2, 1'b0);
    end
    tick();

    // Wrap: rr_ptr=3, owner 3 finishes, index 0 wins next.
    bus.req_data = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    bus.req      = 4'b1001;
    #1;
    expect_out("wrap_bubble", 4'b0000, 8'h00, 1'b0);
    for (int b = 0; b < 3; b++) begin
      tick();
      expect_out("wrap_gnt3", 4'b1000, 8'hC3, 1'b0);
    end
    tick();
    expect_out("wrap_bubble2", 4'b0000, 8'h00, 1'b0);
    tick();
    expect_out("wrap_gnt0", 4'b0001, 8'hC0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares one FIFO write port among NREQ producers.
- Round-robin arbitration with a bounded burst per grant.
- Watermark hysteresis on the FIFO occupancy: grants stop at HIGH_WM and resume at LOW_WM.
- Sits between the producer blocks and the FIFO write side; replaces the single-producer write-enable FSM.

Parameters:
NREQ, 4, number of requesters
DATA_W, 8, data width per requester and to FIFO
CNT_W, 4, width of fifo_words
HIGH_WM, 5, occupancy at or above which writes stop (must be <= FIFO depth)
LOW_WM, 2, occupancy at or below which writes resume (LOW_WM < HIGH_WM)
BURST, 3, max beats per grant (>= 1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous, active-low reset
req  input  NREQ  per-requester write request; data valid while high
req_data  input  NREQ*DATA_W  requester i data on bits [i*DATA_W +: DATA_W]
gnt  output  NREQ  one-hot; gnt[i]=1 means req_data[i] is written this cycle
fifo_words  input  CNT_W  current FIFO occupancy
wr_en  output  1  FIFO write enable
fifo_data  output  DATA_W  FIFO write data
throttled  output  1  high while in THROTTLED state

Behaviour:
- Registered state: state {IDLE, GRANT, THROTTLED}, owner (index), rr_ptr (index), beat_cnt (0..BURST-1).
- Reset (async, rst_n=0): state=IDLE, owner=0, rr_ptr=0, beat_cnt=0. Outputs gnt=0, wr_en=0, fifo_data=0, throttled=0 immediately while reset is asserted.
- Combinational outputs:
  - gnt[owner] = (state==GRANT) & req[owner] & (fifo_words < HIGH_WM). All other gnt bits are 0.
  - wr_en = |gnt.
  - fifo_data = req_data[owner] when wr_en=1, else 0.
  - throttled = (state==THROTTLED).
- Zero-latency write: data is accepted in the same cycle gnt is high. A requester holds req and data stable until gnt; it may drop req at any time.
- IDLE:
  - fifo_words >= HIGH_WM -> THROTTLED.
  - else if any req: winner = first set req scanning rr_ptr, rr_ptr+1, ..., mod NREQ. owner <= winner, beat_cnt <= 0, -> GRANT.
  - else stay in IDLE.
  - No beat is written in IDLE: each grant costs exactly one arbitration bubble cycle.
- GRANT, conditions evaluated in priority order:
  - fifo_words >= HIGH_WM -> THROTTLED, rr_ptr <= owner+1; no beat this cycle.
  - else if !req[owner] -> IDLE, rr_ptr <= owner+1.
  - else (beat written) if beat_cnt==BURST-1 -> IDLE, rr_ptr <= owner+1; otherwise beat_cnt++.
- THROTTLED: fifo_words <= LOW_WM -> IDLE; otherwise stay. Occupancy between LOW_WM and HIGH_WM does not release the throttle (hysteresis).
- Index arithmetic: owner+1 wraps modulo NREQ (NREQ-1 -> 0).
- Overflow guarantee: because gnt is gated combinationally by fifo_words < HIGH_WM, occupancy never exceeds HIGH_WM from this block's writes.
- Simultaneous events:
  - The high watermark takes precedence over burst end and req drop.
  - A req that rises in the same cycle IDLE arbitrates is eligible.
- Reset mid-burst aborts the burst with no partial state retained. Arbitration restarts from rr_ptr=0.

Test Plan:
- Reset: rst_n=0 while GRANT with gnt[1]=1 -> gnt, wr_en, fifo_data, throttled all 0 in the same cycle. After release with only req[3]=1, fifo_words=0 -> IDLE for 1 cycle, then gnt=4'b1000.
- Single producer: req=4'b0001, req_data[7:0]=8'h11 held, fifo_words=0 -> repeating pattern: 1 bubble cycle, then 3 cycles of wr_en=1 with fifo_data=8'h11.
- Full contention: req=4'b1111, data 8'hA0..8'hA3, fifo_words=0 -> grants to 0,1,2,3,0 in order. Each grant is 3 beats preceded by 1 bubble; fifo_data matches the owner.
- Hysteresis: during GRANT, drive fifo_words=5 -> gnt=0 and wr_en=0 in the same cycle, throttled=1 next cycle. fifo_words=3 -> throttled stays 1. fifo_words=2 -> throttled=0 next cycle. Then IDLE, and the grant goes to the requester after the interrupted owner.
- Early release: req=4'b0101, owner 0 drops req after 1 beat -> IDLE next cycle, then gnt=4'b0100 for 3 beats.
- Wrap: rr_ptr=3, req=4'b1001, owner 3 finishes its burst -> next winner is index 0, not 3.
